// File: rtl/sc_cmd_sequencer.sv
// sc_cmd_sequencer
//    Command sequencer for the stream-cipher datapath. Parses UART command
//    characters (L = load key, E = encrypt, D = decrypt, CR = end of command),
//    drives every scdp control strobe and paces transmit bytes against the
//    UART tx busy handshake.
// Ports
//    clk, rst              system clock, synchronous active-high reset
//    bu_rx_data_rdy        rx character valid (1-cycle pulse)
//    de_bigE/D/L, de_hex,  rx character class flags, qualified by
//    de_cr, scdCharIsValid bu_rx_data_rdy
//    tx_busy               UART tx cannot accept a byte this cycle
//    sccEncrypt/Decrypt    mode levels
//    sccEldByte, sccEmsBitsLd, sccElsBitsLd  plaintext latch / LFSR step
//    sccEmsBitsSl          tx mux selects most-significant hex digit
//    sccDnibble1En/2En     cipher nibble captures (2En also steps LFSR)
//    sccLdKey              one-hot key nibble load, one cycle after the char
//    sccLdLFSR             load LFSR from key registers
//    L4_tx_data_rdy        tx byte valid
//    L4_PrintBuf           flush tx buffer
//    L4_led                [0] idle [1] key [2] encrypt [3] decrypt [4] error
module sc_cmd_sequencer #(
   parameter int KEY_NIBBLES = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bu_rx_data_rdy,
   input  logic                   de_bigE,
   input  logic                   de_bigD,
   input  logic                   de_bigL,
   input  logic                   de_hex,
   input  logic                   de_cr,
   input  logic                   scdCharIsValid,
   input  logic                   tx_busy,
   output logic                   sccEncrypt,
   output logic                   sccDecrypt,
   output logic                   sccEldByte,
   output logic                   sccEmsBitsLd,
   output logic                   sccElsBitsLd,
   output logic                   sccEmsBitsSl,
   output logic                   sccDnibble1En,
   output logic                   sccDnibble2En,
   output logic [KEY_NIBBLES-1:0] sccLdKey,
   output logic                   sccLdLFSR,
   output logic                   L4_tx_data_rdy,
   output logic                   L4_PrintBuf,
   output logic [4:0]             L4_led
);

   localparam int CW = (KEY_NIBBLES > 1) ? $clog2(KEY_NIBBLES) : 1;
   localparam logic [CW-1:0] LAST_NIB = CW'(KEY_NIBBLES - 1);
   localparam logic [KEY_NIBBLES-1:0] KEY_MSB = KEY_NIBBLES'(1) << (KEY_NIBBLES - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_KEY, S_KEY_CR, S_ENC, S_ENC_MS, S_ENC_LS,
      S_DEC_HI, S_DEC_LO, S_DEC_OUT
   } state_t;

   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic                   r_err;
   logic [KEY_NIBBLES-1:0] r_ldkey;

   logic w_rx;
   logic w_cr;
   logic w_hex;
   logic w_tx_st;
   logic w_enc_st;
   logic w_dec_st;

   // Reset masks the rx qualifier so no command strobe escapes during reset.
   assign w_rx     = bu_rx_data_rdy & ~rst;
   assign w_cr     = w_rx & de_cr;
   assign w_hex    = w_rx & de_hex & ~de_cr;
   assign w_tx_st  = (r_state == S_ENC_MS) || (r_state == S_ENC_LS) || (r_state == S_DEC_OUT);
   assign w_enc_st = (r_state == S_ENC) || (r_state == S_ENC_MS) || (r_state == S_ENC_LS);
   assign w_dec_st = (r_state == S_DEC_HI) || (r_state == S_DEC_LO) || (r_state == S_DEC_OUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_ldkey <= '0;
      end else begin
         r_ldkey <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_rx) begin
                  if (de_bigE) begin
                     r_state <= S_ENC;
                     r_err   <= 1'b0;
                  end else if (de_bigD) begin
                     r_state <= S_DEC_HI;
                     r_err   <= 1'b0;
                  end else if (de_bigL) begin
                     r_state <= S_KEY;
                     r_cnt   <= '0;
                     r_err   <= 1'b0;
                  end
               end
            end
            S_KEY: begin
               if (w_cr) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end else if (w_hex) begin
                  // First nibble lands in the most-significant key register.
                  r_ldkey <= KEY_MSB >> r_cnt;
                  if (r_cnt == LAST_NIB) r_state <= S_KEY_CR;
                  else                   r_cnt   <= r_cnt + CW'(1);
               end
            end
            S_KEY_CR: if (w_cr) r_state <= S_IDLE;
            S_ENC: begin
               if (w_cr)                         r_state <= S_IDLE;
               else if (w_rx && scdCharIsValid) r_state <= S_ENC_MS;
            end
            S_ENC_MS: begin
               if (w_rx)      r_err   <= 1'b1;
               if (!tx_busy)  r_state <= S_ENC_LS;
            end
            S_ENC_LS: begin
               if (w_rx)      r_err   <= 1'b1;
               if (!tx_busy)  r_state <= S_ENC;
            end
            S_DEC_HI: begin
               if (w_cr)       r_state <= S_IDLE;
               else if (w_hex) r_state <= S_DEC_LO;
            end
            S_DEC_LO: begin
               if (w_cr) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b1;
               end else if (w_hex) begin
                  r_state <= S_DEC_OUT;
               end
            end
            S_DEC_OUT: begin
               if (w_rx)      r_err   <= 1'b1;
               if (!tx_busy)  r_state <= S_DEC_HI;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Levels come straight from registered state; strobes that must coincide
   // with the rx character or the tx handshake are decoded from state and
   // the qualifying input in the same cycle.
   always_comb begin
      sccEncrypt     = w_enc_st;
      sccDecrypt     = w_dec_st;
      sccEmsBitsSl   = (r_state == S_ENC_MS);
      sccEldByte     = (r_state == S_ENC) && w_rx && scdCharIsValid && !de_cr;
      sccEmsBitsLd   = sccEldByte;
      sccElsBitsLd   = sccEldByte;
      sccDnibble1En  = (r_state == S_DEC_HI) && w_hex;
      sccDnibble2En  = (r_state == S_DEC_LO) && w_hex;
      sccLdKey       = r_ldkey;
      sccLdLFSR      = (r_state == S_KEY_CR) && w_cr;
      L4_tx_data_rdy = w_tx_st && !tx_busy && !rst;
      L4_PrintBuf    = w_cr && ((r_state == S_IDLE) || (r_state == S_KEY_CR) ||
                                (r_state == S_ENC)  || (r_state == S_DEC_HI));
      L4_led         = {r_err, w_dec_st, w_enc_st,
                        (r_state == S_KEY) || (r_state == S_KEY_CR),
                        (r_state == S_IDLE)};
   end

endmodule

// File: tb/tb_sc_cmd_sequencer.sv
// tb_sc_cmd_sequencer
//    Self-checking bench for sc_cmd_sequencer. Each cycle's expected output
//    vector is queued when the stimulus is driven; the observed vector is
//    queued at the falling edge, and each scenario task drains and compares.
module tb_sc_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bu_rx_data_rdy = 1'b0;
   logic       de_bigE = 1'b0, de_bigD = 1'b0, de_bigL = 1'b0;
   logic       de_hex = 1'b0, de_cr = 1'b0, scdCharIsValid = 1'b0;
   logic       tx_busy = 1'b0;
   logic       sccEncrypt, sccDecrypt, sccEldByte, sccEmsBitsLd, sccElsBitsLd;
   logic       sccEmsBitsSl, sccDnibble1En, sccDnibble2En, sccLdLFSR;
   logic       L4_tx_data_rdy, L4_PrintBuf;
   logic [7:0] sccLdKey;
   logic [4:0] L4_led;

   sc_cmd_sequencer #(.KEY_NIBBLES(8)) dut (
      .clk(clk), .rst(rst), .bu_rx_data_rdy(bu_rx_data_rdy),
      .de_bigE(de_bigE), .de_bigD(de_bigD), .de_bigL(de_bigL),
      .de_hex(de_hex), .de_cr(de_cr), .scdCharIsValid(scdCharIsValid),
      .tx_busy(tx_busy), .sccEncrypt(sccEncrypt), .sccDecrypt(sccDecrypt),
      .sccEldByte(sccEldByte), .sccEmsBitsLd(sccEmsBitsLd),
      .sccElsBitsLd(sccElsBitsLd), .sccEmsBitsSl(sccEmsBitsSl),
      .sccDnibble1En(sccDnibble1En), .sccDnibble2En(sccDnibble2En),
      .sccLdKey(sccLdKey), .sccLdLFSR(sccLdLFSR),
      .L4_tx_data_rdy(L4_tx_data_rdy), .L4_PrintBuf(L4_PrintBuf),
      .L4_led(L4_led)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       enc, dec, eld, ems, els, sl, d1, d2;
      logic [7:0] key;
      logic       lfsr, tx, pbuf;
      logic [4:0] led;
   } ov_t;

   // Expected FSM state names (bench side)
   localparam int T_IDLE = 0, T_KEY = 1, T_KCR = 2, T_ENC = 3, T_EMS = 4,
                  T_ELS = 5, T_DHI = 6, T_DLO = 7, T_DOUT = 8;
   // Pulse flags
   localparam int P_ELD = 1, P_D1 = 2, P_D2 = 4, P_LFSR = 8, P_TX = 16, P_PBUF = 32;
   // Stimulus: {rst, rdy, E, D, L, hex, cr, printable}
   localparam logic [7:0] CH_NONE = 8'b0000_0000;
   localparam logic [7:0] CH_RST  = 8'b1000_0000;
   localparam logic [7:0] CH_E    = 8'b0110_0101;
   localparam logic [7:0] CH_D    = 8'b0101_0101;
   localparam logic [7:0] CH_L    = 8'b0100_1001;
   localparam logic [7:0] CH_H    = 8'b0100_0101;
   localparam logic [7:0] CH_CR   = 8'b0100_0010;
   localparam logic [7:0] CH_P    = 8'b0100_0001;

   ov_t q_exp[$];
   ov_t q_act[$];
   int  n_cmp = 0;
   int  n_mis = 0;

   function automatic ov_t ex(input int st, input logic err, input int p, input logic [7:0] key);
      ov_t v;
      v      = '0;
      v.enc  = (st == T_ENC) || (st == T_EMS) || (st == T_ELS);
      v.dec  = (st == T_DHI) || (st == T_DLO) || (st == T_DOUT);
      v.sl   = (st == T_EMS);
      v.eld  = (p & P_ELD) != 0;
      v.ems  = v.eld;
      v.els  = v.eld;
      v.d1   = (p & P_D1) != 0;
      v.d2   = (p & P_D2) != 0;
      v.lfsr = (p & P_LFSR) != 0;
      v.tx   = (p & P_TX) != 0;
      v.pbuf = (p & P_PBUF) != 0;
      v.key  = key;
      v.led  = {err, v.dec, v.enc, (st == T_KEY) || (st == T_KCR), st == T_IDLE};
      return v;
   endfunction

   function automatic ov_t sample();
      ov_t v;
      v = {sccEncrypt, sccDecrypt, sccEldByte, sccEmsBitsLd, sccElsBitsLd,
           sccEmsBitsSl, sccDnibble1En, sccDnibble2En, sccLdKey, sccLdLFSR,
           L4_tx_data_rdy, L4_PrintBuf, L4_led};
      return v;
   endfunction

   task automatic cyc(input logic [7:0] ch, input logic busy, input ov_t e);
      @(posedge clk);
      #1;
      {rst, bu_rx_data_rdy, de_bigE, de_bigD, de_bigL, de_hex, de_cr, scdCharIsValid} = ch;
      tx_busy = busy;
      q_exp.push_back(e);
      @(negedge clk);
      q_act.push_back(sample());
   endtask

   task automatic test_reset();
      ov_t e, a;
      int  k = 0;
      cyc(CH_RST,  0, ex(T_IDLE, 0, 0, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 0, 0, 8'h00));
      cyc(CH_P,    0, ex(T_IDLE, 0, 0, 8'h00));
      cyc(CH_CR,   0, ex(T_IDLE, 0, P_PBUF, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 0, 0, 8'h00));
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); a = q_act.pop_front(); n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL test_reset[%0d]: got %h expected %h", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_key_load();
      ov_t        e, a;
      int         k = 0;
      int         n = 0;
      logic [7:0] kexp = 8'h00;
      logic [7:0] ch;
      cyc(CH_L, 0, ex(T_IDLE, 0, 0, 8'h00));
      // eight hex digits with one ignored non-hex char in the middle
      for (int i = 0; i < 9; i++) begin
         ch = (i == 4) ? CH_P : CH_H;
         cyc(ch, 0, ex(T_KEY, 0, 0, kexp));
         if (ch == CH_H) begin
            kexp = 8'h80 >> n;
            n++;
         end else begin
            kexp = 8'h00;
         end
      end
      cyc(CH_P,    0, ex(T_KCR, 0, 0, kexp));
      cyc(CH_CR,   0, ex(T_KCR, 0, P_LFSR | P_PBUF, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 0, 0, 8'h00));
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); a = q_act.pop_front(); n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL test_key_load[%0d]: got %h expected %h", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_encrypt();
      ov_t e, a;
      int  k = 0;
      cyc(CH_E,    0, ex(T_IDLE, 0, 0, 8'h00));
      cyc(CH_H,    0, ex(T_ENC,  0, P_ELD, 8'h00));
      cyc(CH_NONE, 0, ex(T_EMS,  0, P_TX, 8'h00));
      cyc(CH_NONE, 0, ex(T_ELS,  0, P_TX, 8'h00));
      cyc(CH_CR,   0, ex(T_ENC,  0, P_PBUF, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 0, 0, 8'h00));
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); a = q_act.pop_front(); n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL test_encrypt[%0d]: got %h expected %h", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_enc_stall();
      ov_t e, a;
      int  k = 0;
      cyc(CH_E, 0, ex(T_IDLE, 0, 0, 8'h00));
      cyc(CH_H, 1, ex(T_ENC,  0, P_ELD, 8'h00));
      // tx_busy high 5 cycles; a char arriving mid-stall is an overrun
      for (int i = 0; i < 5; i++)
         cyc((i == 2) ? CH_H : CH_NONE, 1, ex(T_EMS, i > 2, 0, 8'h00));
      cyc(CH_NONE, 0, ex(T_EMS,  1, P_TX, 8'h00));
      cyc(CH_NONE, 0, ex(T_ELS,  1, P_TX, 8'h00));
      cyc(CH_NONE, 0, ex(T_ENC,  1, 0, 8'h00));
      cyc(CH_CR,   0, ex(T_ENC,  1, P_PBUF, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 1, 0, 8'h00));
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); a = q_act.pop_front(); n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL test_enc_stall[%0d]: got %h expected %h", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_decrypt();
      ov_t e, a;
      int  k = 0;
      cyc(CH_D,    0, ex(T_IDLE, 1, 0, 8'h00));
      cyc(CH_H,    0, ex(T_DHI,  0, P_D1, 8'h00));
      cyc(CH_H,    0, ex(T_DLO,  0, P_D2, 8'h00));
      cyc(CH_NONE, 1, ex(T_DOUT, 0, 0, 8'h00));
      cyc(CH_NONE, 0, ex(T_DOUT, 0, P_TX, 8'h00));
      cyc(CH_H,    0, ex(T_DHI,  0, P_D1, 8'h00));
      cyc(CH_CR,   0, ex(T_DLO,  0, 0, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 1, 0, 8'h00));
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); a = q_act.pop_front(); n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL test_decrypt[%0d]: got %h expected %h", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_key_short();
      ov_t e, a;
      int  k = 0;
      cyc(CH_L,    0, ex(T_IDLE, 1, 0, 8'h00));
      cyc(CH_H,    0, ex(T_KEY,  0, 0, 8'h00));
      cyc(CH_H,    0, ex(T_KEY,  0, 0, 8'h80));
      cyc(CH_H,    0, ex(T_KEY,  0, 0, 8'h40));
      cyc(CH_CR,   0, ex(T_KEY,  0, 0, 8'h20));
      cyc(CH_NONE, 0, ex(T_IDLE, 1, 0, 8'h00));
      cyc(CH_E,    0, ex(T_IDLE, 1, 0, 8'h00));
      cyc(CH_NONE, 0, ex(T_ENC,  0, 0, 8'h00));
      cyc(CH_CR,   0, ex(T_ENC,  0, P_PBUF, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 0, 0, 8'h00));
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); a = q_act.pop_front(); n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL test_key_short[%0d]: got %h expected %h", k, a, e);
         end
         k++;
      end
   endtask

   task automatic test_reset_mid();
      ov_t e, a;
      int  k = 0;
      cyc(CH_E,    0, ex(T_IDLE, 0, 0, 8'h00));
      cyc(CH_H,    1, ex(T_ENC,  0, P_ELD, 8'h00));
      cyc(CH_NONE, 1, ex(T_EMS,  0, 0, 8'h00));
      cyc(CH_RST,  1, ex(T_EMS,  0, 0, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 0, 0, 8'h00));
      cyc(CH_NONE, 0, ex(T_IDLE, 0, 0, 8'h00));
      while (q_exp.size() > 0) begin
         e = q_exp.pop_front(); a = q_act.pop_front(); n_cmp++;
         if (a !== e) begin
            n_mis++;
            $display("FAIL test_reset_mid[%0d]: got %h expected %h", k, a, e);
         end
         k++;
      end
   endtask

   initial begin
      test_reset();
      test_key_load();
      test_encrypt();
      test_enc_stall();
      test_decrypt();
      test_key_short();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
